// File: rtl/conv_monitor.sv
// rtl/conv_monitor.sv - multi-channel setpoint convergence monitor with dwell and timeout
// Declares a run passed once every enabled channel holds |actual-target| <= tol for dwell samples.
module conv_monitor #(
    parameter int NCH    = 3,
    parameter int WIDTH  = 16,
    parameter int STICKY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH*WIDTH-1:0]   target,
    input  logic [NCH*WIDTH-1:0]   actual,
    input  logic                   sample_vld,
    input  logic [WIDTH-1:0]       tol,
    input  logic [15:0]            dwell,
    input  logic [23:0]            timeout,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NCH-1:0]         conv_mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MON  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NCH-1:0]       ch_en_q, ch_en_d;
    logic [NCH*WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0]     tol_q, tol_d;
    logic [15:0]          dwell_q, dwell_d;
    logic [23:0]          timeout_q, timeout_d;
    logic [15:0]          run_cnt_q [NCH];
    logic [15:0]          run_cnt_d [NCH];
    logic [23:0]          samp_cnt_q, samp_cnt_d;
    logic [NCH-1:0]       conv_mask_q, conv_mask_d;
    logic                 pass_q, pass_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [15:0]          cnt_step [NCH];
    logic [NCH-1:0]       mask_step;
    logic [NCH-1:0]       in_band;
    logic [23:0]          samp_step;
    logic                 all_conv_step;
    logic                 timeout_hit;
    logic                 run_end;

    // One extra bit keeps full-scale opposite-sign differences exact.
    for (genvar g = 0; g < NCH; g++) begin : g_err
        logic signed [WIDTH:0] act_x;
        logic signed [WIDTH:0] tgt_x;
        logic signed [WIDTH:0] diff;
        logic        [WIDTH:0] mag;

        assign act_x = {actual[g*WIDTH+WIDTH-1], actual[g*WIDTH +: WIDTH]};
        assign tgt_x = {target_q[g*WIDTH+WIDTH-1], target_q[g*WIDTH +: WIDTH]};
        assign diff  = act_x - tgt_x;
        assign mag   = diff[WIDTH] ? (~diff + 1'b1) : diff;
        assign in_band[g] = (mag <= {1'b0, tol_q});
    end

    // Candidate counter/mask values if the current cycle carries a sample.
    always_comb begin
        mask_step = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_step[i] = 16'd0;
            if (!ch_en_q[i]) begin
                mask_step[i] = 1'b1;
            end else begin
                if (!in_band[i]) begin
                    cnt_step[i] = 16'd0;
                end else if (run_cnt_q[i] >= dwell_q) begin
                    cnt_step[i] = dwell_q;
                end else begin
                    cnt_step[i] = run_cnt_q[i] + 16'd1;
                end
                if (STICKY != 0) begin
                    mask_step[i] = conv_mask_q[i] | (cnt_step[i] == dwell_q);
                end else begin
                    mask_step[i] = (cnt_step[i] == dwell_q);
                end
            end
        end
        samp_step     = samp_cnt_q + 24'd1;
        all_conv_step = &mask_step;
        timeout_hit   = (timeout_q != 24'd0) && (samp_step == timeout_q);
    end

    // A run with every channel disabled ends without waiting for a sample.
    assign run_end = (state_q == S_MON) &&
                     ((&conv_mask_q) || (sample_vld && (all_conv_step || timeout_hit)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_MON;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_MON:   if (run_end) state_d = S_FIN;
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        done_d = (state_d == S_FIN);
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        ch_en_d     = ch_en_q;
        target_d    = target_q;
        tol_d       = tol_q;
        dwell_d     = dwell_q;
        timeout_d   = timeout_q;
        run_cnt_d   = run_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        conv_mask_d = conv_mask_q;
        pass_d      = pass_q;
        if (start) begin
            ch_en_d     = ch_en;
            target_d    = target;
            tol_d       = tol;
            dwell_d     = (dwell == 16'd0) ? 16'd1 : dwell;
            timeout_d   = timeout;
            for (int i = 0; i < NCH; i++) begin
                run_cnt_d[i] = 16'd0;
            end
            samp_cnt_d  = 24'd0;
            conv_mask_d = ~ch_en;
            pass_d      = 1'b0;
        end else if (state_q == S_MON) begin
            if (&conv_mask_q) begin
                pass_d = 1'b1;
            end else if (sample_vld) begin
                run_cnt_d   = cnt_step;
                conv_mask_d = mask_step;
                samp_cnt_d  = samp_step;
                pass_d      = all_conv_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_en_q     <= '0;
            target_q    <= '0;
            tol_q       <= '0;
            dwell_q     <= '0;
            timeout_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                run_cnt_q[i] <= 16'd0;
            end
            samp_cnt_q  <= '0;
            conv_mask_q <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ch_en_q     <= ch_en_d;
            target_q    <= target_d;
            tol_q       <= tol_d;
            dwell_q     <= dwell_d;
            timeout_q   <= timeout_d;
            run_cnt_q   <= run_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            conv_mask_q <= conv_mask_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign conv_mask = conv_mask_q;

endmodule

// File: tb/tb_conv_monitor.sv
// tb/tb_conv_monitor.sv - directed bench for conv_monitor (sticky and non-sticky instances)
module tb_conv_monitor;

    logic        clk = 1'b0;
    logic        rst, start, sample_vld;
    logic [2:0]  ch_en;
    logic [47:0] target, actual;
    logic [15:0] tol, dwell;
    logic [23:0] timeout;
    logic        busy, done, pass;
    logic [2:0]  conv_mask;
    logic        busy0, done0, pass0;
    logic [2:0]  conv_mask0;

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int done_cnt0 = 0;

    always #5 clk = ~clk;

    conv_monitor #(.NCH(3), .WIDTH(16), .STICKY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .target(target),
        .actual(actual), .sample_vld(sample_vld), .tol(tol), .dwell(dwell),
        .timeout(timeout), .busy(busy), .done(done), .pass(pass), .conv_mask(conv_mask)
    );

    conv_monitor #(.NCH(3), .WIDTH(16), .STICKY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .target(target),
        .actual(actual), .sample_vld(sample_vld), .tol(tol), .dwell(dwell),
        .timeout(timeout), .busy(busy0), .done(done0), .pass(pass0), .conv_mask(conv_mask0)
    );

    always @(negedge clk) begin
        if (done)  done_cnt  <= done_cnt + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic samp(input logic [47:0] a);
        actual     = a;
        sample_vld = 1'b1;
        step();
        sample_vld = 1'b0;
    endtask

    function automatic logic [47:0] pack(input logic [15:0] a0, input logic [15:0] a1,
                                         input logic [15:0] a2);
        return {a2, a1, a0};
    endfunction

    initial begin
        int          hit;
        int          snap;
        logic [15:0] d;
        logic [15:0] seq [7];

        rst = 1'b1; start = 1'b1; sample_vld = 1'b0;
        ch_en = 3'b111; target = '0; actual = '0;
        tol = '0; dwell = '0; timeout = '0;
        step();
        step();
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_pass",  64'(pass),      64'd0);
        chk("rst_mask",  64'(conv_mask), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        step();

        // Ramp: error d=50-k reaches tol at sample 46, dwell 8 -> converged at 53.
        ch_en = 3'b111; target = pack(16'h00AA, 16'h0099, 16'h0066);
        tol = 16'd4; dwell = 16'd8; timeout = 24'd1000;
        snap = done_cnt;
        do_start();
        chk("ramp_busy", 64'(busy), 64'd1);
        hit = 0;
        for (int k = 1; k <= 100 && hit == 0; k++) begin
            d = (k < 50) ? 16'(50 - k) : 16'd0;
            samp(pack(16'h00AA - d, 16'h0099 - d, 16'h0066 - d));
            if (done) hit = k;
        end
        chk("ramp_done_at", 64'(hit),       64'd53);
        chk("ramp_pass",    64'(pass),      64'd1);
        chk("ramp_mask",    64'(conv_mask), 64'd7);
        chk("ramp_busy_fin", 64'(busy),     64'd1);
        step();
        chk("ramp_busy_fall", 64'(busy), 64'd0);
        chk("ramp_done_fall", 64'(done), 64'd0);
        step(); step(); step();
        chk("ramp_done_once", 64'(done_cnt - snap), 64'd1);

        // Channel 1 stuck at zero: timeout at sample 1000.
        do_start();
        chk("stuck_pass_cleared", 64'(pass), 64'd0);
        hit = 0;
        for (int k = 1; k <= 1100 && hit == 0; k++) begin
            samp(pack(16'h00AA, 16'h0000, 16'h0066));
            if (done) hit = k;
        end
        chk("stuck_done_at", 64'(hit),       64'd1000);
        chk("stuck_pass",    64'(pass),      64'd0);
        chk("stuck_mask",    64'(conv_mask), 64'd5);
        step();
        samp(pack(16'h00AA, 16'h0099, 16'h0066));
        samp(pack(16'h00AA, 16'h0099, 16'h0066));
        chk("idle_mask_hold", 64'(conv_mask), 64'd5);
        chk("idle_busy",      64'(busy),      64'd0);

        // Band edge: error == tol counts, tol+1 clears; done at 7th sample.
        ch_en = 3'b001; target = pack(16'h0010, 16'h0000, 16'h0000);
        tol = 16'd4; dwell = 16'd3; timeout = 24'd0;
        seq[0] = 16'h0014; seq[1] = 16'h000C; seq[2] = 16'h0015; seq[3] = 16'h000B;
        seq[4] = 16'h0010; seq[5] = 16'h0014; seq[6] = 16'h000C;
        do_start();
        chk("edge_mask_start", 64'(conv_mask), 64'd6);
        hit = 0;
        for (int i = 0; i < 7; i++) begin
            samp(pack(seq[i], 16'h0000, 16'h0000));
            if (i == 5) chk("edge_mask_s6", 64'(conv_mask), 64'd6);
            if (done && hit == 0) hit = i + 1;
        end
        chk("edge_done_at", 64'(hit),  64'd7);
        chk("edge_pass",    64'(pass), 64'd1);
        step();

        // Full-scale opposite signs: error 0xFFFF.
        target = pack(16'h7FFF, 16'h0000, 16'h0000);
        tol = 16'hFFFF; dwell = 16'd4; timeout = 24'd0;
        do_start();
        hit = 0;
        for (int k = 1; k <= 10 && hit == 0; k++) begin
            samp(pack(16'h8000, 16'h0000, 16'h0000));
            if (done) hit = k;
        end
        chk("fs_done_at", 64'(hit),  64'd4);
        chk("fs_pass",    64'(pass), 64'd1);
        step();
        tol = 16'hFFFE; timeout = 24'd3;
        do_start();
        hit = 0;
        for (int k = 1; k <= 10 && hit == 0; k++) begin
            samp(pack(16'h8000, 16'h0000, 16'h0000));
            if (done) hit = k;
        end
        chk("fs_narrow_done_at", 64'(hit),       64'd3);
        chk("fs_narrow_pass",    64'(pass),      64'd0);
        chk("fs_narrow_mask",    64'(conv_mask), 64'd6);
        step();

        // dwell=0 behaves as 1.
        target = pack(16'h0005, 16'h0000, 16'h0000);
        tol = 16'd0; dwell = 16'd0; timeout = 24'd0;
        do_start();
        samp(pack(16'h0005, 16'h0000, 16'h0000));
        chk("dwell0_done", 64'(done), 64'd1);
        chk("dwell0_pass", 64'(pass), 64'd1);
        step();

        // No channels enabled: done one cycle after start.
        ch_en = 3'b000;
        do_start();
        chk("none_busy",  64'(busy), 64'd1);
        chk("none_done0", 64'(done), 64'd0);
        step();
        chk("none_done",  64'(done),      64'd1);
        chk("none_pass",  64'(pass),      64'd1);
        chk("none_mask",  64'(conv_mask), 64'd7);
        step();

        // Non-sticky vs sticky: one out-of-band sample after convergence.
        ch_en = 3'b011; target = '0;
        tol = 16'd2; dwell = 16'd8; timeout = 24'd0;
        do_start();
        for (int k = 0; k < 8; k++) samp(pack(16'd0, 16'd100, 16'd0));
        chk("ns_mask_conv", 64'(conv_mask0), 64'd5);
        samp(pack(16'd50, 16'd100, 16'd0));
        chk("ns_mask_drop", 64'(conv_mask0), 64'd4);
        chk("st_mask_hold", 64'(conv_mask),  64'd5);
        chk("ns_no_done",   64'(done0),      64'd0);
        hit = 0;
        for (int k = 1; k <= 12 && hit == 0; k++) begin
            samp(pack(16'd0, 16'd0, 16'd0));
            if (done0) hit = k;
        end
        chk("ns_done_at", 64'(hit),   64'd8);
        chk("ns_pass",    64'(pass0), 64'd1);
        step();

        // Restart at sample 20, then reset mid-run: no done at all.
        ch_en = 3'b111; target = pack(16'h00AA, 16'h0099, 16'h0066);
        tol = 16'd4; dwell = 16'd8; timeout = 24'd1000;
        step();
        snap = done_cnt;
        do_start();
        for (int k = 0; k < 20; k++) samp(pack(16'h00AA, 16'h0000, 16'h0066));
        chk("rs_mask_pre", 64'(conv_mask), 64'd5);
        do_start();
        chk("rs_mask_clr", 64'(conv_mask), 64'd0);
        chk("rs_busy",     64'(busy),      64'd1);
        for (int k = 0; k < 5; k++) samp(pack(16'h00AA, 16'h0000, 16'h0066));
        chk("rs_cnt_clr", 64'(conv_mask), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_rst_busy", 64'(busy),      64'd0);
        chk("rs_rst_done", 64'(done),      64'd0);
        chk("rs_rst_pass", 64'(pass),      64'd0);
        chk("rs_rst_mask", 64'(conv_mask), 64'd0);
        step(); step(); step();
        chk("rs_no_done", 64'(done_cnt - snap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_monitor.md
CONV_MONITOR -- requirements
Module: conv_monitor

Interface
REQ-001 Parameter NCH, default 3: number of monitored channels (e.g. pitch/roll/yaw); legal 1..8.
REQ-002 Parameter WIDTH, default 16: signed width of each target/actual value.
REQ-003 Parameter STICKY, default 1: 1 = converged status latches; 0 = an out-of-band sample drops convergence.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; arms a monitoring run.
REQ-007 ch_en  in  NCH  per-channel enable, captured at start.
REQ-008 target  in  NCH*WIDTH  signed setpoints, channel i at [i*WIDTH +: WIDTH], captured at start.
REQ-009 actual  in  NCH*WIDTH  signed measured values, same packing, live.
REQ-010 sample_vld  in  1  strobe: actual is a new valid sample.
REQ-011 tol  in  WIDTH  unsigned band half-width, captured at start.
REQ-012 dwell  in  16  required consecutive in-band samples, captured at start.
REQ-013 timeout  in  24  max sample strobes per run, captured at start; 0 = no timeout.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse at run end.
REQ-016 pass  out  1  result of last run, valid from done until next start.
REQ-017 conv_mask  out  NCH  per-channel converged status.

Function
REQ-018 FSM states IDLE, MON, FIN; IDLE->MON on start; MON->FIN on completion; FIN->IDLE unconditionally next cycle, done=1 only in FIN.
REQ-019 Error per channel |actual-target| computed in WIDTH+1 bits; no overflow at full-scale opposite signs.
REQ-020 Sample in-band iff error <= tol (inclusive).
REQ-021 Per-channel 16-bit run counter: +1 on in-band sample_vld, cleared on out-of-band sample_vld, saturates at dwell.
REQ-022 Channel converged when counter reaches effective dwell; dwell=0 treated as 1.
REQ-023 STICKY=1: conv_mask bit stays set for rest of run; STICKY=0: bit follows counter==dwell each sample.
REQ-024 Disabled channels: counter held 0, conv_mask bit forced 1.
REQ-025 Run completes with pass=1 on the sample where all conv_mask bits are 1; FIN entered next cycle.
REQ-026 Sample counter increments per sample_vld in MON; at count==timeout (nonzero) run completes with pass=0.
REQ-027 Convergence and timeout on same sample: pass=1.
REQ-028 ch_en all zero at start: MON completes on next cycle with pass=1, no sample required.
REQ-029 start while in MON or FIN: run restarts; counters cleared, inputs recaptured, no done for aborted run.
REQ-030 sample_vld outside MON ignored; conv_mask/pass hold last run's values in IDLE.
REQ-031 All outputs registered; busy=1 in MON and FIN.

Reset
REQ-032 rst overrides all inputs including start; state IDLE, busy=0, done=0, pass=0, conv_mask=0, all counters and captured registers 0.
REQ-033 rst mid-run aborts with no done pulse.

Verification
REQ-034 NCH=3, targets 0x00AA/0x0099/0x0066, tol=4, dwell=8, timeout=1000, actuals ramp to targets by sample 50 -> done once, pass=1, conv_mask=3'b111, busy falls with done.
REQ-035 Same, channel 1 stuck at 0x0000 -> done at sample 1000, pass=0, conv_mask=3'b101.
REQ-036 Target 0x7FFF, actual 0x8000, tol=0xFFFF -> no overflow; in-band; pass=1 after dwell samples.
REQ-037 STICKY=0, channel in band 8 samples then one out-of-band sample -> conv_mask bit clears, counter restarts, no premature done.
REQ-038 Error exactly tol -> counted in-band; tol+1 -> counter cleared.
REQ-039 start reissued at sample 20 of a run, then rst mid-run -> no done for either aborted run, all outputs 0 after rst.
